// File: rtl/aes_mcu_mc.sv
// Control unit that shares one AES core among NUM_CH Rx/Tx FIFO channel pairs.
// It handles key loading, round-robin channel service, and wait-state timeouts.
module aes_mcu_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              key_in,
  input  logic              generation_done,
  input  logic              is_encryption_pulse,
  input  logic              is_decryption_pulse,
  input  logic [NUM_CH-1:0] emptyRx,
  input  logic [NUM_CH-1:0] fullRx,
  input  logic [NUM_CH-1:0] fullTx,
  input  logic              accepted,
  input  logic              data_done,
  output logic              is_encrypt,
  output logic              mcu_key_in,
  output logic              read_fifo,
  output logic [NUM_CH-1:0] rcv_deq,
  output logic [NUM_CH-1:0] trans_enq,
  output logic [CH_W-1:0]   ch_sel,
  output logic [CNT_W-1:0]  blk_count,
  output logic [3:0]        status_bits
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, KEY_REQ, KEY_WAIT, READY, DEQ, WAIT_ACC, WAIT_DONE, ENQ, ERROR
  } state_t;

  state_t             state_reg, state_next;
  logic [CH_W-1:0]    ch_sel_reg, last_served_reg;
  logic [CNT_W-1:0]   blk_count_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic               is_encrypt_reg, err_reg, ovf_reg;

  logic [NUM_CH-1:0]  eligible;
  logic               pick_valid;
  logic [CH_W-1:0]    pick_ch;
  int                 rr_idx;
  logic               tmo_hit, wait_state, enq_fire;

  assign eligible   = ~emptyRx & ~fullTx;
  assign tmo_hit    = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
  assign wait_state = (state_reg == KEY_WAIT) || (state_reg == WAIT_ACC) ||
                      (state_reg == WAIT_DONE) || (state_reg == ENQ);
  assign enq_fire   = (state_reg == ENQ) && !fullTx[ch_sel_reg];

  // Scan downward so the channel closest after last_served is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    rr_idx     = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_idx = (int'(last_served_reg) + i) % NUM_CH;
      if (eligible[rr_idx]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (key_in) state_next = KEY_REQ;
      KEY_REQ:   state_next = KEY_WAIT;
      KEY_WAIT:  if (generation_done) state_next = READY;
                 else if (tmo_hit)    state_next = ERROR;
      READY:     if (key_in)          state_next = KEY_REQ;
                 else if (pick_valid) state_next = DEQ;
      DEQ:       state_next = WAIT_ACC;
      WAIT_ACC:  if (accepted)     state_next = WAIT_DONE;
                 else if (tmo_hit) state_next = ERROR;
      WAIT_DONE: if (data_done)    state_next = ENQ;
                 else if (tmo_hit) state_next = ERROR;
      ENQ:       if (enq_fire)     state_next = READY;
                 else if (tmo_hit) state_next = ERROR;
      ERROR:     if (key_in) state_next = KEY_REQ;
      default:   state_next = IDLE;
    endcase
  end

  // Strobes are state decodes; trans_enq is additionally held off while the Tx FIFO is full.
  always_comb begin
    mcu_key_in  = (state_reg == KEY_REQ);
    read_fifo   = (state_reg == DEQ);
    status_bits = '0;
    status_bits[0] = (state_reg == READY) || (state_reg == DEQ) || (state_reg == WAIT_ACC) ||
                     (state_reg == WAIT_DONE) || (state_reg == ENQ);
    status_bits[1] = (state_reg == KEY_REQ) || (state_reg == KEY_WAIT) || (state_reg == DEQ) ||
                     (state_reg == WAIT_ACC) || (state_reg == WAIT_DONE) || (state_reg == ENQ);
    status_bits[2] = err_reg;
    status_bits[3] = ovf_reg;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_strobe
      assign rcv_deq[gi]   = (state_reg == DEQ) && (ch_sel_reg == CH_W'(gi));
      assign trans_enq[gi] = enq_fire && (ch_sel_reg == CH_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tmo_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      tmo_cnt_reg <= '0;
    end else if (wait_state) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ch_sel_reg      <= '0;
      last_served_reg <= CH_W'(NUM_CH - 1);
      blk_count_reg   <= '0;
      is_encrypt_reg  <= 1'b1;
      err_reg         <= 1'b0;
      ovf_reg         <= 1'b0;
    end else begin
      if (state_reg == READY && !key_in && pick_valid)
        ch_sel_reg <= pick_ch;
      if (enq_fire) begin
        last_served_reg <= ch_sel_reg;
        if (blk_count_reg != '1)
          blk_count_reg <= blk_count_reg + 1'b1;
      end
      if ((state_reg == IDLE || state_reg == READY) &&
          (is_encryption_pulse ^ is_decryption_pulse))
        is_encrypt_reg <= is_encryption_pulse;
      if (state_next == KEY_REQ)
        err_reg <= 1'b0;
      else if (state_next == ERROR && state_reg != ERROR)
        err_reg <= 1'b1;
      if (|fullRx)
        ovf_reg <= 1'b1;
    end
  end

  assign is_encrypt = is_encrypt_reg;
  assign ch_sel     = ch_sel_reg;
  assign blk_count  = blk_count_reg;

endmodule

// File: doc/aes_mcu_mc.md
AES_MCU_MC -- requirements
Module: aes_mcu_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of Rx/Tx FIFO channel pairs sharing one AES core (2..8).
REQ-002 Parameter CNT_W, default 16, width of processed-block counter.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles spent in any wait state before error.
REQ-004 clk  in  1  sole clock, rising-edge active.
REQ-005 n_reset  in  1  asynchronous, active-low reset.
REQ-006 key_in  in  1  one-cycle request to load a new key.
REQ-007 generation_done  in  1  key expansion complete (level).
REQ-008 is_encryption_pulse / is_decryption_pulse  in  1 each  mode select pulses.
REQ-009 emptyRx, fullRx, fullTx  in  NUM_CH each  per-channel FIFO flags.
REQ-010 accepted  in  1  AES core has latched input block.
REQ-011 data_done  in  1  AES result valid.
REQ-012 is_encrypt  out  1  1 = encrypt, 0 = decrypt.
REQ-013 mcu_key_in  out  1  one-cycle key-load strobe to key generator.
REQ-014 read_fifo  out  1  AES load strobe, coincident with rcv_deq.
REQ-015 rcv_deq, trans_enq  out  NUM_CH each  one-hot dequeue/enqueue strobes.
REQ-016 ch_sel  out  clog2(NUM_CH)  channel currently served.
REQ-017 blk_count  out  CNT_W  blocks completed since reset.
REQ-018 status_bits  out  4  [0] key_valid, [1] busy, [2] timeout error (sticky), [3] Rx overflow (sticky).

Function
REQ-019 States: IDLE, KEY_REQ, KEY_WAIT, READY, DEQ, WAIT_ACC, WAIT_DONE, ENQ, ERROR; all outputs decoded from registered state (Moore).
REQ-020 IDLE/READY/ERROR + key_in -> KEY_REQ; key_in ignored in all other states.
REQ-021 KEY_REQ: mcu_key_in=1 exactly one cycle, key_valid and error bit cleared, -> KEY_WAIT.
REQ-022 KEY_WAIT: generation_done=1 -> key_valid=1, -> READY.
REQ-023 Channel c eligible when emptyRx[c]=0 and fullTx[c]=0.
REQ-024 READY: round-robin search starting at last_served+1 (mod NUM_CH); first eligible channel latched into ch_sel, -> DEQ next edge.
REQ-025 READY with key_in and an eligible channel on the same edge: key_in wins.
REQ-026 DEQ: rcv_deq[ch_sel]=1 and read_fifo=1 for exactly one cycle, -> WAIT_ACC.
REQ-027 WAIT_ACC: accepted=1 -> WAIT_DONE; WAIT_DONE: data_done=1 -> ENQ.
REQ-028 ENQ: fullTx[ch_sel]=1 holds in ENQ; else trans_enq[ch_sel]=1 one cycle, blk_count+1 (saturating at all-ones), last_served<=ch_sel, -> READY.
REQ-029 Timeout counter clears on every state entry, increments each cycle in KEY_WAIT, WAIT_ACC, WAIT_DONE, ENQ; reaching TIMEOUT_CYC -> ERROR, status_bits[2]=1.
REQ-030 ERROR: all strobes 0, key_valid=0; exit only via key_in.
REQ-031 Mode pulses update is_encrypt only in IDLE or READY; ignored elsewhere; both pulses in the same cycle -> no change.
REQ-032 busy = 1 in DEQ, WAIT_ACC, WAIT_DONE, ENQ, KEY_REQ, KEY_WAIT.
REQ-033 status_bits[3] sets when any fullRx bit is 1 and remains set until reset.
REQ-034 At most one bit of rcv_deq and trans_enq high at any time; never both vectors high in the same cycle.

Reset
REQ-035 n_reset=0 immediately forces IDLE, is_encrypt=1, all strobes 0, ch_sel=0, last_served=NUM_CH-1, blk_count=0, status_bits=4'b0000, timeout counter 0.
REQ-036 Reset mid-block abandons the block with no trans_enq issued; first key_in after release proceeds normally.

Verification
REQ-037 Reset, key_in pulse, generation_done high 3 cycles later -> mcu_key_in high exactly 1 cycle, status_bits=4'b0001 in READY.
REQ-038 Key valid, emptyRx=4'b1110 -> rcv_deq=0001 + read_fifo 1 cycle; accepted, data_done -> trans_enq=0001, blk_count=1.
REQ-039 emptyRx=4'b0000 held for 4 blocks -> service order ch 0,1,2,3 then 0.
REQ-040 emptyRx[1]=0 with fullTx[1]=1 and emptyRx[2]=0 -> channel 2 served, channel 1 skipped.
REQ-041 accepted never asserted -> ERROR after TIMEOUT_CYC cycles, status_bits[2]=1; key_in -> KEY_REQ, bit 2 cleared.
REQ-042 is_decryption_pulse during WAIT_DONE -> is_encrypt stays 1; same pulse in READY -> is_encrypt=0 next cycle.
